// File: rtl/sd_spi_responder.sv
// sd_spi_responder: card-side SPI-mode SD command responder.
// Receives 48-bit command frames on mosi, answers with an R1 byte after NCR
// filler cycles, and for a legal CMD17 fetches one word from backing memory
// and returns it as a 0xFE-tokened data block.
//
// Ports:
//   clk        single clock, all sampling/driving on the rising edge
//   reset      asynchronous active-low reset
//   cs         chip select, active low
//   mosi       host-to-card serial data
//   miso       card-to-host serial data (registered)
//   busy       high whenever the responder is not idle
//   cmd_valid  one-cycle pulse when a complete frame is accepted
//   cmd_index  index of the last accepted frame
//   cmd_arg    argument of the last accepted frame
//   rd_en      one-cycle read strobe to backing memory
//   rd_addr    read word address, valid with rd_en
//   rd_data    read word, valid one cycle after rd_en
//
// state    | meaning
// IDLE     | miso=1, waiting for a start bit with cs low
// RX_CMD   | shifting in frame bits 46..0
// NCR_WAIT | NCR filler cycles of ones before R1
// TX_R1    | driving the R1 byte, MSB first
// NAC_WAIT | NAC filler cycles; memory read issued and captured here
// TX_TOKEN | driving the 0xFE start token
// TX_DATA  | driving the 32-bit read word, MSB first
module sd_spi_responder #(
    parameter int NCR       = 2,
    parameter int NAC       = 4,
    parameter int CHECK_CRC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        busy,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RX_CMD   = 3'd1;
    localparam logic [2:0] NCR_WAIT = 3'd2;
    localparam logic [2:0] TX_R1    = 3'd3;
    localparam logic [2:0] NAC_WAIT = 3'd4;
    localparam logic [2:0] TX_TOKEN = 3'd5;
    localparam logic [2:0] TX_DATA  = 3'd6;

    localparam logic [7:0] TOKEN     = 8'hFE;
    localparam logic [5:0] NCR_LAST  = 6'(NCR - 1);
    localparam logic [5:0] NAC_LAST  = 6'(NAC - 1);
    localparam logic [5:0] NAC_LATCH = 6'(NAC - 2);

    logic [2:0]  state;
    logic [5:0]  cnt;
    // Holds frame bits 45..1 by the time bit 0 is on mosi; bits 47/46 are
    // fixed framing bits and are checked on the fly instead of stored.
    logic [44:0] frame_sr;
    logic [6:0]  crc;
    logic [31:0] tx_sr;
    logic [31:0] data_word;
    logic        idle_flag;
    logic        do_read;

    logic [5:0]  rx_index;
    logic [31:0] rx_arg;
    logic        crc_err;
    logic        illegal;
    logic        idle_next;
    logic [7:0]  r1_new;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign busy      = (state != IDLE);
    assign rx_index  = frame_sr[44:39];
    assign rx_arg    = frame_sr[38:7];
    assign crc_err   = (CHECK_CRC != 0) && (crc != frame_sr[6:0]);
    // CMD17 reads the idle flag as it stood before this frame; CMD17 never
    // changes it, so the order does not matter for the result.
    assign illegal   = !((rx_index == 6'd0) || (rx_index == 6'd1) ||
                         ((rx_index == 6'd17) && !idle_flag));
    assign idle_next = crc_err             ? idle_flag :
                       (rx_index == 6'd0)  ? 1'b1      :
                       (rx_index == 6'd1)  ? 1'b0      : idle_flag;
    assign r1_new    = {4'b0000, crc_err, illegal, 1'b0, idle_next};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_sr  <= '0;
            crc       <= '0;
            tx_sr     <= '0;
            data_word <= '0;
            idle_flag <= 1'b1;
            do_read   <= 1'b0;
            miso      <= 1'b1;
            cmd_valid <= 1'b0;
            cmd_index <= '0;
            cmd_arg   <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
        end else begin
            cmd_valid <= 1'b0;
            rd_en     <= 1'b0;
            miso      <= 1'b1;
            case (state)
                IDLE: begin
                    if (!cs && !mosi) begin
                        state    <= RX_CMD;
                        cnt      <= 6'd46;
                        frame_sr <= '0;
                        crc      <= '0;
                    end
                end
                RX_CMD: begin
                    frame_sr <= {frame_sr[43:0], mosi};
                    if (cnt >= 6'd8) crc <= crc7_step(crc, mosi);
                    if (cs) begin
                        state <= IDLE;
                    end else if (cnt == 6'd46 && !mosi) begin
                        state <= IDLE;
                    end else if (cnt == 6'd0) begin
                        cmd_valid <= 1'b1;
                        cmd_index <= rx_index;
                        cmd_arg   <= rx_arg;
                        idle_flag <= idle_next;
                        do_read   <= (rx_index == 6'd17) && !illegal && !crc_err;
                        tx_sr     <= {r1_new, 24'h000000};
                        cnt       <= NCR_LAST;
                        state     <= NCR_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                NCR_WAIT: begin
                    if (cs) begin
                        state <= IDLE;
                    end else if (cnt == 6'd0) begin
                        miso  <= tx_sr[31];
                        tx_sr <= tx_sr << 1;
                        cnt   <= 6'd7;
                        state <= TX_R1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_R1: begin
                    if (cs) begin
                        state <= IDLE;
                    end else if (cnt == 6'd0) begin
                        if (do_read) begin
                            rd_en   <= 1'b1;
                            rd_addr <= cmd_arg;
                            cnt     <= NAC_LAST;
                            state   <= NAC_WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        miso  <= tx_sr[31];
                        tx_sr <= tx_sr << 1;
                        cnt   <= cnt - 1'b1;
                    end
                end
                NAC_WAIT: begin
                    // rd_en was high during the first NAC cycle, so the word
                    // is on rd_data during the second one.
                    if (cnt == NAC_LATCH) data_word <= rd_data;
                    if (cs) begin
                        state <= IDLE;
                    end else if (cnt == 6'd0) begin
                        miso  <= TOKEN[7];
                        tx_sr <= {TOKEN[6:0], 25'd0};
                        cnt   <= 6'd7;
                        state <= TX_TOKEN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_TOKEN: begin
                    if (cs) begin
                        state <= IDLE;
                    end else if (cnt == 6'd0) begin
                        miso  <= data_word[31];
                        tx_sr <= {data_word[30:0], 1'b0};
                        cnt   <= 6'd31;
                        state <= TX_DATA;
                    end else begin
                        miso  <= tx_sr[31];
                        tx_sr <= tx_sr << 1;
                        cnt   <= cnt - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (cs || cnt == 6'd0) begin
                        state <= IDLE;
                    end else begin
                        miso  <= tx_sr[31];
                        tx_sr <= tx_sr << 1;
                        cnt   <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder: drives two responders (CRC checking on / off) with the
// same host stimulus and compares each against a frame-level reference model.
module tb_sd_spi_responder;

    localparam int NCR = 2;
    localparam int NAC = 4;
    localparam int W   = NCR + 8 + NAC + 8 + 32 + 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        mosi;
    logic [1:0]  miso_s, busy_s, cv_s, rden_s;
    logic [5:0]  idx_s  [2];
    logic [31:0] arg_s  [2];
    logic [31:0] addr_s [2];
    logic [31:0] rdd_s  [2];

    int n_checks = 0;
    int n_errors = 0;
    bit idle_m [2];

    always #5 clk = ~clk;

    sd_spi_responder #(.NCR(NCR), .NAC(NAC), .CHECK_CRC(1)) dut_crc (
        .clk(clk), .reset(reset), .cs(cs), .mosi(mosi),
        .miso(miso_s[0]), .busy(busy_s[0]), .cmd_valid(cv_s[0]),
        .cmd_index(idx_s[0]), .cmd_arg(arg_s[0]),
        .rd_en(rden_s[0]), .rd_addr(addr_s[0]), .rd_data(rdd_s[0])
    );

    sd_spi_responder #(.NCR(NCR), .NAC(NAC), .CHECK_CRC(0)) dut_nocrc (
        .clk(clk), .reset(reset), .cs(cs), .mosi(mosi),
        .miso(miso_s[1]), .busy(busy_s[1]), .cmd_valid(cv_s[1]),
        .cmd_index(idx_s[1]), .cmd_arg(arg_s[1]),
        .rd_en(rden_s[1]), .rd_addr(addr_s[1]), .rd_data(rdd_s[1])
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // Backing memory: the word is only valid in the one cycle after rd_en.
    always @(posedge clk) begin
        for (int j = 0; j < 2; j++)
            rdd_s[j] <= rden_s[j] ? mem_word(addr_s[j]) : $urandom();
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg, input bit good);
        logic [6:0] c;
        c = crc7({2'b01, idx, arg});
        if (!good) c = c ^ 7'($urandom_range(1, 127));
        return {2'b01, idx, arg, c, 1'b1};
    endfunction

    // Sends one frame, then watches W cycles of response on both instances.
    // abort_at >= 0 cuts the response at that window cycle, by reset pulse
    // (by_reset=1) or by raising cs.
    task automatic xfer(input logic [47:0] frame, input int abort_at, input bit by_reset, input string tag);
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [7:0]   r1;
        logic [7:0]   tok;
        logic [31:0]  dw;
        bit           crc_ok, err, ill;
        bit           rd [2];
        bit           seq [W];
        logic [127:0] es [2];
        logic [127:0] obs [2];
        int           cvn [2], cvk [2], rdn [2], rdk [2];
        logic [31:0]  rda [2];
        logic [37:0]  cap [2];
        int           stop;
        logic [1:0]   last_busy;

        idx    = frame[45:40];
        arg    = frame[39:8];
        crc_ok = (crc7(frame[47:8]) == frame[7:1]);
        tok    = 8'hFE;
        dw     = mem_word(arg);
        for (int j = 0; j < 2; j++) begin
            err = (j == 0) && !crc_ok;
            ill = !(idx == 0 || idx == 1 || (idx == 17 && !idle_m[j]));
            if (!err && idx == 0) idle_m[j] = 1'b1;
            else if (!err && idx == 1) idle_m[j] = 1'b0;
            r1    = {4'b0000, err, ill, 1'b0, idle_m[j]};
            rd[j] = (idx == 17) && !ill && !err;
            for (int k = 0; k < W; k++) seq[k] = 1'b1;
            for (int b = 0; b < 8; b++) seq[NCR + b] = r1[7 - b];
            if (rd[j]) begin
                for (int b = 0; b < 8; b++)  seq[NCR + 8 + NAC + b] = tok[7 - b];
                for (int b = 0; b < 32; b++) seq[NCR + 16 + NAC + b] = dw[31 - b];
            end
            es[j] = '0;
            for (int k = 0; k < W; k++) es[j] = {es[j][126:0], seq[k]};
            obs[j] = '0; cvn[j] = 0; cvk[j] = 0; rdn[j] = 0; rdk[j] = 0;
            rda[j] = '0; cap[j] = '0;
        end

        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            mosi = frame[47 - i];
        end

        stop = W;
        last_busy = 2'b11;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            mosi = 1'b1;
            for (int j = 0; j < 2; j++) begin
                obs[j] = {obs[j][126:0], miso_s[j]};
                if (cv_s[j]) begin
                    if (cvn[j] == 0) begin
                        cvk[j] = k;
                        cap[j] = {idx_s[j], arg_s[j]};
                    end
                    cvn[j]++;
                end
                if (rden_s[j]) begin
                    if (rdn[j] == 0) begin
                        rdk[j] = k;
                        rda[j] = addr_s[j];
                    end
                    rdn[j]++;
                end
            end
            last_busy = busy_s;
            if (k == abort_at) begin
                stop = k + 1;
                if (by_reset) begin
                    reset = 1'b0;
                    #1;
                    chk({tag, "_rst_out"}, {miso_s, busy_s}, {2'b11, 2'b00});
                    #1;
                    reset = 1'b1;
                    idle_m[0] = 1'b1;
                    idle_m[1] = 1'b1;
                end else begin
                    cs = 1'b1;
                    @(negedge clk);
                    chk({tag, "_cs_out"}, {miso_s, busy_s}, {2'b11, 2'b00});
                    cs = 1'b0;
                end
                break;
            end
        end

        for (int j = 0; j < 2; j++) begin
            bit rd_exp;
            rd_exp = rd[j] && (NCR + 8 < stop);
            chk($sformatf("%s_miso%0d", tag, j), obs[j], es[j] >> (W - stop));
            chk($sformatf("%s_cv%0d", tag, j), {cvn[j], cvk[j]}, {32'd1, 32'd0});
            chk($sformatf("%s_cmd%0d", tag, j), cap[j], {idx, arg});
            chk($sformatf("%s_rd%0d", tag, j), {rdn[j], rdk[j], rda[j]},
                rd_exp ? {32'd1, 32'(NCR + 8), arg} : {32'd0, 32'd0, 32'd0});
        end
        if (stop == W) chk({tag, "_busy_end"}, last_busy, 2'b00);
    endtask

    // Watches n idle-looking cycles: no cmd_valid, miso held high.
    task automatic quiet(input int n, output logic [1:0] cv_any, output logic [1:0] miso_all);
        cv_any = 2'b00;
        miso_all = 2'b11;
        repeat (n) begin
            @(negedge clk);
            cv_any   = cv_any | cv_s;
            miso_all = miso_all & miso_s;
        end
    endtask

    initial begin
        logic [47:0] f;
        logic [1:0]  cva, ma, cvb, mb;
        logic [5:0]  ridx;

        reset = 1'b0;
        cs    = 1'b1;
        mosi  = 1'b1;
        idle_m[0] = 1'b1;
        idle_m[1] = 1'b1;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 2; j++)
            chk($sformatf("reset_state%0d", j),
                {miso_s[j], busy_s[j], cv_s[j], rden_s[j], idx_s[j], arg_s[j], addr_s[j]},
                {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0});
        reset = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        repeat (2) @(negedge clk);

        xfer(48'h400000000095, -1, 0, "cmd0");
        xfer(48'h400000000000, -1, 0, "cmd0_badcrc");
        xfer(mk(6'd17, 32'h10, 1), -1, 0, "cmd17_idle");
        xfer(mk(6'd8, 32'h1AA, 1), -1, 0, "cmd8");
        xfer(48'h4100000000F9, -1, 0, "cmd1");
        xfer(mk(6'd17, 32'h10, 1), -1, 0, "cmd17_read");

        // Frame cut short by cs after 20 bits, then a normal CMD0.
        f = 48'h400000000095;
        cva = 2'b00; ma = 2'b11;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mosi = f[47 - i];
            ma = ma & miso_s;
        end
        @(negedge clk);
        cs = 1'b1;
        mosi = 1'b1;
        quiet(6, cvb, mb);
        chk("abort20", {cva | cvb, ma & mb, busy_s}, {2'b00, 2'b11, 2'b00});
        cs = 1'b0;
        xfer(48'h400000000095, -1, 0, "cmd0_after_abort");

        // Transmission bit 0: frame discarded right after bit 46.
        @(negedge clk); mosi = 1'b0;
        @(negedge clk); mosi = 1'b0;
        @(negedge clk); mosi = 1'b1;
        quiet(8, cvb, mb);
        chk("discard", {cvb, mb, busy_s}, {2'b00, 2'b11, 2'b00});

        xfer(mk(6'd1, 32'h0, 1), -1, 0, "cmd1b");
        xfer(mk(6'd17, 32'h123, 1), NCR + 8 + NAC + 8 + 10, 0, "cs_mid_data");
        xfer(mk(6'd17, 32'h20, 1), -1, 0, "cmd17_after_cs");
        xfer(48'h4100000000F9, NCR + 3, 1, "rst_mid_r1");
        xfer(48'h400000000095, -1, 0, "cmd0_after_rst");
        xfer(mk(6'd17, 32'h30, 0), -1, 0, "cmd17_badcrc_idle");
        xfer(mk(6'd1, 32'h0, 1), -1, 0, "cmd1c");
        xfer(mk(6'd17, 32'h40, 0), -1, 0, "cmd17_badcrc");

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 5))
                0: ridx = 6'd0;
                1: ridx = 6'd1;
                2, 3: ridx = 6'd17;
                4: ridx = 6'd8;
                default: ridx = 6'($urandom_range(0, 63));
            endcase
            xfer(mk(ridx, $urandom(), $urandom_range(0, 3) != 0), -1, 0, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter NCR, default 2: count of all-ones MISO cycles between the command end bit and the R1 MSB; legal range 1..8.
REQ-002 Parameter NAC, default 4: count of all-ones MISO cycles between the R1 LSB and the data token; legal range 2..16.
REQ-003 Parameter CHECK_CRC, default 1: when 1, CRC7 mismatches are reported; when 0, the CRC field is ignored.
REQ-004 clk  in  1  single clock; all sampling and driving on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cs  in  1  chip select, active low.
REQ-007 mosi  in  1  host-to-card serial data.
REQ-008 miso  out  1  card-to-host serial data, registered.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 cmd_valid  out  1  one-cycle pulse when a complete frame is accepted.
REQ-011 cmd_index  out  6  index of the last accepted frame, held until the next frame is accepted.
REQ-012 cmd_arg  out  32  argument of the last accepted frame, held until the next frame is accepted.
REQ-013 rd_en  out  1  one-cycle read strobe to backing memory.
REQ-014 rd_addr  out  32  read word address; valid while rd_en is high.
REQ-015 rd_data  in  32  read word; valid exactly 1 cycle after rd_en.

Function
REQ-016 States SHALL be IDLE, RX_CMD, NCR_WAIT, TX_R1, NAC_WAIT, TX_TOKEN, TX_DATA.
REQ-017 IDLE: miso=1; with cs=0, a sampled mosi=0 is the frame start bit (bit 47) -> RX_CMD with bit counter=46.
REQ-018 RX_CMD SHALL shift one mosi bit per cycle, MSB first, until bit 0 (48 bits total, including the start bit).
REQ-019 Bit 46 (transmission bit) sampled as 0 SHALL discard the frame -> IDLE, with no response and no cmd_valid.
REQ-020 CRC7 SHALL be computed over bits 47..8 with polynomial x^7+x^3+1 and initial value 0; it is compared against bits 7..1; bit 0 is ignored.
REQ-021 On the cycle after bit 0 is sampled: cmd_valid pulses, cmd_index and cmd_arg update, R1 is composed, and the state -> NCR_WAIT.
REQ-022 R1 fields: bit7=0; bit0=idle flag; bit2=illegal command; bit3=CRC error (CHECK_CRC=1 and mismatch); all other bits 0.
REQ-023 idle flag SHALL reset to 1.
REQ-024 CMD0 SHALL set the idle flag.
REQ-025 CMD1 SHALL clear the idle flag; CMD1's own R1 reports idle=0.
REQ-026 CMD17 is legal only when idle=0; in every other case CMD17, and any index other than 0, 1 or 17, sets the illegal bit.
REQ-027 A frame with a CRC error SHALL NOT change the idle flag and SHALL NOT start a read.
REQ-028 NCR_WAIT: miso=1 for NCR cycles, then TX_R1.
REQ-029 TX_R1: R1 driven MSB first, one bit per cycle, 8 cycles; then NAC_WAIT if this is a legal, CRC-clean CMD17, otherwise IDLE.
REQ-030 NAC_WAIT: miso=1 for NAC cycles; rd_en pulses on the first cycle with rd_addr=cmd_arg; rd_data is latched on the second cycle; then TX_TOKEN.
REQ-031 TX_TOKEN: 0xFE driven MSB first over 8 cycles; then TX_DATA.
REQ-032 TX_DATA: the latched word driven MSB first over 32 cycles; then miso=1 and the state -> IDLE.
REQ-033 cs=1 in RX_CMD SHALL abort to IDLE with no cmd_valid and no state side effects.
REQ-034 cs=1 in any transmit or wait state SHALL abort to IDLE with miso=1 on the next cycle; an idle-flag update already made is kept.
REQ-035 Frames arriving while busy outside IDLE SHALL be ignored; mosi is monitored only in IDLE and RX_CMD.
REQ-036 Bit counters SHALL NOT wrap; every state exits on its terminal count.

Reset
REQ-037 reset low SHALL asynchronously force: state=IDLE, miso=1, busy=0, cmd_valid=0, rd_en=0, rd_addr=0, cmd_index=0, cmd_arg=0, idle flag=1, counters=0, shift registers=0.
REQ-038 Deassertion of reset SHALL take effect on the next clk edge; a frame in progress at reset is lost.

Verification
REQ-039 Reset pulse mid-TX_R1 -> miso=1 immediately; busy=0; the next CMD0 gets R1=0x01.
REQ-040 CMD0 bytes 40 00 00 00 00 95 -> cmd_valid pulse, cmd_index=0; 2 cycles of miso=1; then R1 bits 0,0,0,0,0,0,0,1.
REQ-041 CMD0 with CRC byte 0x00, CHECK_CRC=1 -> R1=0x09; the same stimulus with CHECK_CRC=0 -> R1=0x01.
REQ-042 CMD1 (41 00 00 00 00 F9) -> R1=0x00; then CMD17 with arg 0x00000010 and bench-computed CRC, rd_data=0xDEADBEEF -> R1=0x00, rd_en with rd_addr=0x10, 4 cycles of ones, 0xFE, then DEADBEEF MSB first, then miso=1.
REQ-043 After reset, CMD17 -> R1=0x05 and no rd_en; CMD8 -> R1=0x05.
REQ-044 cs raised after 20 frame bits -> no cmd_valid and miso stays 1; the following complete CMD0 is accepted normally.
